// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite-memory DMA engine and the PPU register
// decode that sits downstream of it.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALT  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'h4014;
  localparam logic [2:0]  OAMDATA_SEL_DEFAULT  = 3'h4;

  localparam int unsigned OAM_BYTES = 256;
  localparam logic [7:0]  OAM_LAST_IDX = 8'(OAM_BYTES - 1);

  // PPU register selects for CPU addresses $2000-$2007
  localparam logic [2:0] RI_PPUCTRL   = 3'd0;
  localparam logic [2:0] RI_PPUMASK   = 3'd1;
  localparam logic [2:0] RI_PPUSTATUS = 3'd2;
  localparam logic [2:0] RI_OAMADDR   = 3'd3;
  localparam logic [2:0] RI_OAMDATA   = 3'd4;
  localparam logic [2:0] RI_PPUSCROLL = 3'd5;
  localparam logic [2:0] RI_PPUADDR   = 3'd6;
  localparam logic [2:0] RI_PPUDATA   = 3'd7;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to the DMA register halts the CPU and copies one
// 256-byte CPU page into PPU OAMDATA, one memory read then one ri write
// strobe per byte. All outputs are decoded from registered state only.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter logic [2:0]  OAMDATA_SEL  = OAMDATA_SEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_r_nw,
  input  logic [7:0]  mem_din,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] mem_a,
  output logic [2:0]  ri_sel,
  output logic        ri_ncs,
  output logic        ri_r_nw,
  output logic [7:0]  ri_dout
);

  dma_state_e state, state_d;
  logic [7:0] page, page_d;
  logic [7:0] idx, idx_d;
  logic [7:0] data, data_d;
  logic       trigger;

  assign trigger = !cpu_r_nw && (cpu_a == DMA_REG_ADDR);

  // State and datapath registers; everything advances only on CPU-rate strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      page  <= '0;
      idx   <= '0;
      data  <= '0;
    end else if (cpu_ce) begin
      state <= state_d;
      page  <= page_d;
      idx   <= idx_d;
      data  <= data_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state;
    page_d  = page;
    idx_d   = idx;
    data_d  = data;
    unique case (state)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = cpu_din;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_READ;
      ST_READ: begin
        data_d  = mem_din;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx == OAM_LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx + 8'd1;
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; ri_dout follows the data register, which only
  // changes entering WRITE, so it holds the last byte everywhere else
  always_comb begin
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    mem_a      = '0;
    ri_sel     = '0;
    ri_ncs     = 1'b1;
    ri_r_nw    = 1'b1;
    ri_dout    = data;
    unique case (state)
      ST_HALT, ST_READ: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        mem_a      = {page, idx};
      end
      ST_WRITE: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        mem_a      = {page, idx};
        ri_sel     = OAMDATA_SEL;
        ri_ncs     = 1'b0;
        ri_r_nw    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
